// File: rtl/maxpool22_ctrl_pkg.sv
// Shared types and sizing helpers for the layer controllers (conv / pool sequencers).
package maxpool22_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } layer_state_e;

  // Row/column counter width for a square map; at least one bit.
  function automatic int unsigned ctr_width(input int unsigned map_size);
    return (map_size > 2) ? $clog2(map_size) : 1;
  endfunction

  // Width of a pooled (halved) coordinate; at least one bit.
  function automatic int unsigned pooled_width(input int unsigned map_size);
    return (map_size > 4) ? $clog2(map_size) - 1 : 1;
  endfunction

endpackage

// File: rtl/maxpool22_ctrl_raster.sv
// Raster-order row/column position counter for a MAP_SIZE x MAP_SIZE map.
module maxpool22_ctrl_raster
  import maxpool22_ctrl_pkg::*;
#(
  parameter int unsigned  MAP_SIZE = 28,
  localparam int unsigned CW       = ctr_width(MAP_SIZE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          adv,
  output logic [CW-1:0] row,
  output logic [CW-1:0] col,
  output logic          last_c
);

  localparam logic [CW-1:0] LAST = CW'(MAP_SIZE - 1);

  assign last_c = (row == LAST) && (col == LAST);

  // Column wraps into the next row; row holds at the last line until cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row <= '0;
      col <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
    end else if (adv) begin
      if (col == LAST) begin
        col <= '0;
        if (row != LAST) row <= row + CW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

endmodule

// File: rtl/maxpool22_ctrl.sv
// Sequencer for the 2x2 max-pool line buffer: handshakes the pixel stream, drives the
// pool's active-low shift enable and flags cycles where maxOut holds an aligned window.
module maxpool22_ctrl
  import maxpool22_ctrl_pkg::*;
#(
  parameter int unsigned  MAP_SIZE = 28,
  localparam int unsigned CW       = ctr_width(MAP_SIZE),
  localparam int unsigned OW       = pooled_width(MAP_SIZE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          out_ready,
  output logic          pool_en,
  output logic          out_valid,
  output logic [OW-1:0] out_row,
  output logic [OW-1:0] out_col,
  output logic          busy,
  output logic          frame_done
);

  localparam int unsigned NRES = (MAP_SIZE / 2) * (MAP_SIZE / 2);
  localparam int unsigned RW   = $clog2(NRES + 1);

  layer_state_e  state, state_d;
  logic          accept;
  logic          handshake;
  logic          last_res;
  logic          win_done;
  logic          cnt_clr;
  logic          last_pix_c;
  logic [CW-1:0] row, col;
  logic [RW-1:0] res_cnt;

  assign cnt_clr = (state == ST_IDLE);

  maxpool22_ctrl_raster #(.MAP_SIZE(MAP_SIZE)) u_raster (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr),
    .adv    (accept),
    .row    (row),
    .col    (col),
    .last_c (last_pix_c)
  );

  // Next state plus the combinational handshake; a pending window blocks any shift.
  always_comb begin
    state_d   = state;
    in_ready  = 1'b0;
    accept    = 1'b0;
    handshake = out_valid && out_ready;
    last_res  = handshake && (res_cnt == RW'(NRES - 1));
    case (state)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        in_ready = !(out_valid && !out_ready);
        accept   = in_valid && in_ready;
        if (accept && last_pix_c) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (last_res) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    pool_en = ~accept;
  end

  assign win_done = accept && row[0] && col[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_d;
      busy       <= (state_d != ST_IDLE);
      frame_done <= (state_d == ST_DONE);
    end
  end

  // Result flag and pooled coordinates; consecutive windows never collide with a handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_row   <= '0;
      out_col   <= '0;
      res_cnt   <= '0;
    end else begin
      if (win_done) begin
        out_valid <= 1'b1;
        out_row   <= OW'(row >> 1);
        out_col   <= OW'(col >> 1);
      end else if (handshake) begin
        out_valid <= 1'b0;
      end
      if (cnt_clr)        res_cnt <= '0;
      else if (handshake) res_cnt <= res_cnt + RW'(1);
    end
  end

endmodule

// File: tb/tb_maxpool22_ctrl.sv
// Scoreboard bench: two controllers (4x4 and 28x28) each driving a behavioural 2x2 pool.
module tb_maxpool22_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic       a_start, a_in_valid, a_in_ready, a_out_ready, a_pool_en;
  logic       a_out_valid, a_busy, a_frame_done;
  logic [0:0] a_out_row, a_out_col;
  logic       b_start, b_in_valid, b_in_ready, b_out_ready, b_pool_en;
  logic       b_out_valid, b_busy, b_frame_done;
  logic [3:0] b_out_row, b_out_col;

  int a_pix, b_pix;
  int a_sr[6];
  int b_sr[30];
  int a_maxout, b_maxout;
  int img[784];
  int checks = 0;
  int errors = 0;

  typedef struct {
    int row;
    int col;
    int val;
  } exp_t;
  exp_t qa[$];
  exp_t qb[$];

  maxpool22_ctrl #(.MAP_SIZE(4)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_ready(a_out_ready), .pool_en(a_pool_en), .out_valid(a_out_valid),
    .out_row(a_out_row), .out_col(a_out_col), .busy(a_busy), .frame_done(a_frame_done)
  );

  maxpool22_ctrl #(.MAP_SIZE(28)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_ready(b_out_ready), .pool_en(b_pool_en), .out_valid(b_out_valid),
    .out_row(b_out_row), .out_col(b_out_col), .busy(b_busy), .frame_done(b_frame_done)
  );

  function automatic int max4(input int w, input int x, input int y, input int z);
    int m;
    m = w;
    if (x > m) m = x;
    if (y > m) m = y;
    if (z > m) m = z;
    return m;
  endfunction

  // Behavioural line buffer: shifts on pool_en low, window = two newest of each row.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 6; i++) a_sr[i] <= 0;
    end else if (!a_pool_en) begin
      a_sr[0] <= a_pix;
      for (int i = 1; i < 6; i++) a_sr[i] <= a_sr[i-1];
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 30; i++) b_sr[i] <= 0;
    end else if (!b_pool_en) begin
      b_sr[0] <= b_pix;
      for (int i = 1; i < 30; i++) b_sr[i] <= b_sr[i-1];
    end
  end

  always_comb a_maxout = max4(a_sr[0], a_sr[1], a_sr[4], a_sr[5]);
  always_comb b_maxout = max4(b_sr[0], b_sr[1], b_sr[28], b_sr[29]);

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_res(input string name, input int r, input int c, input int v, input exp_t e);
    checks++;
    if (r != e.row || c != e.col || v != e.val) begin
      errors++;
      $display("FAIL %s: got (%0d,%0d)=%0d expected (%0d,%0d)=%0d", name, r, c, v, e.row, e.col, e.val);
    end
  endtask

  // Monitors: pop and compare on every result handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rst && a_out_valid && a_out_ready) begin
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_extra_result: got (%0d,%0d)=%0d expected none", a_out_row, a_out_col, a_maxout);
      end else begin
        e = qa.pop_front();
        chk_res("a_result", int'(a_out_row), int'(a_out_col), a_maxout, e);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst && b_out_valid && b_out_ready) begin
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_extra_result: got (%0d,%0d)=%0d expected none", b_out_row, b_out_col, b_maxout);
      end else begin
        e = qb.pop_front();
        chk_res("b_result", int'(b_out_row), int'(b_out_col), b_maxout, e);
      end
    end
  end

  task automatic a_push(input int r, input int c, input int v);
    exp_t e;
    e.row = r; e.col = c; e.val = v;
    qa.push_back(e);
  endtask

  // One 4x4 frame of pixels 0..15; optional result stall, start-while-busy, or reset abort.
  task automatic a_frame(input bit stall, input int start_at, input int abort_at);
    int  waitc, stall_cnt, n;
    bit  got, seen;
    a_push(0, 0, 5);
    a_push(0, 1, 7);
    a_push(1, 0, 13);
    a_push(1, 1, 15);
    stall_cnt   = 0;
    a_out_ready = !stall;
    a_start     = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    @(negedge clk);
    chk("a_busy_after_start", int'(a_busy), 1);
    chk("a_ready_after_start", int'(a_in_ready), 1);
    @(posedge clk); #1;
    for (int idx = 0; idx < 16; idx++) begin
      if (idx == abort_at) break;
      a_pix      = idx;
      a_in_valid = 1'b1;
      a_start    = (idx == start_at);
      got   = 1'b0;
      waitc = 0;
      while (!got) begin
        @(negedge clk);
        if (a_in_ready) begin
          got = 1'b1;
        end else begin
          if (stall) begin
            chk("a_stall_pool_en", int'(a_pool_en), 1);
            chk("a_stall_maxout", a_maxout, 5);
            stall_cnt++;
            if (stall_cnt == 4) begin
              @(posedge clk); #1;
              a_out_ready = 1'b1;
            end
          end
          waitc++;
          if (waitc > 50) begin
            chk("a_accept_timeout", 0, 1);
            a_in_valid = 1'b0;
            a_start    = 1'b0;
            return;
          end
        end
      end
      @(posedge clk); #1;
      a_start = 1'b0;
    end
    a_in_valid = 1'b0;
    if (stall) chk("a_stall_cycles", stall_cnt, 4);
    if (abort_at >= 0) begin
      rst = 1'b0;
      #1;
      chk("a_abort_busy", int'(a_busy), 0);
      chk("a_abort_in_ready", int'(a_in_ready), 0);
      chk("a_abort_pool_en", int'(a_pool_en), 1);
      chk("a_abort_out_valid", int'(a_out_valid), 0);
      chk("a_abort_pending", qa.size(), 2);
      qa.delete();
      @(posedge clk); #1;
      rst = 1'b1;
      return;
    end
    n = 0;
    seen = 1'b0;
    while (!seen && n < 10) begin
      @(negedge clk);
      n++;
      if (a_frame_done) seen = 1'b1;
    end
    chk("a_done_latency", n, 2);
    @(negedge clk);
    chk("a_busy_after_done", int'(a_busy), 0);
    chk("a_queue_empty", qa.size(), 0);
    @(posedge clk); #1;
  endtask

  // One 28x28 signed frame with ~50% in_valid gaps, checked against a software max-pool.
  task automatic b_frame();
    int  waitc, n;
    bit  got, seen;
    exp_t e;
    for (int i = 0; i < 784; i++) img[i] = int'($urandom_range(0, 255)) - 128;
    img[0]  = -5;
    img[1]  = -100;
    img[28] = -7;
    img[29] = -128;
    img[783] = 127;
    for (int pr = 0; pr < 14; pr++) begin
      for (int pc = 0; pc < 14; pc++) begin
        e.row = pr;
        e.col = pc;
        e.val = max4(img[(2*pr)*28 + 2*pc], img[(2*pr)*28 + 2*pc + 1],
                     img[(2*pr+1)*28 + 2*pc], img[(2*pr+1)*28 + 2*pc + 1]);
        qb.push_back(e);
      end
    end
    chk("b_expected_count", qb.size(), 196);
    b_out_ready = 1'b1;
    b_start     = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    for (int idx = 0; idx < 784; idx++) begin
      b_pix = img[idx];
      got   = 1'b0;
      waitc = 0;
      while (!got) begin
        b_in_valid = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (b_in_valid && b_in_ready) got = 1'b1;
        else waitc++;
        @(posedge clk); #1;
        if (waitc > 100) begin
          chk("b_accept_timeout", 0, 1);
          b_in_valid = 1'b0;
          return;
        end
      end
    end
    b_in_valid = 1'b0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 10) begin
      @(negedge clk);
      n++;
      if (b_frame_done) seen = 1'b1;
    end
    chk("b_done_latency", n, 2);
    chk("b_queue_empty", qb.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    a_start = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1; a_pix = 0;
    b_start = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b1; b_pix = 0;
    // Reset held with start/in_valid toggling.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      a_start    = (i % 2) == 0;
      a_in_valid = (i % 2) == 1;
      @(negedge clk);
      chk("rst_in_ready", int'(a_in_ready), 0);
      chk("rst_pool_en", int'(a_pool_en), 1);
      chk("rst_out_valid", int'(a_out_valid), 0);
      chk("rst_out_pos", int'({a_out_row, a_out_col}), 0);
      chk("rst_busy", int'(a_busy), 0);
      chk("rst_frame_done", int'(a_frame_done), 0);
    end
    @(posedge clk); #1;
    a_start = 1'b0;
    a_in_valid = 1'b0;
    rst = 1'b1;
    // in_valid while IDLE is ignored.
    a_in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_in_ready", int'(a_in_ready), 0);
      chk("idle_pool_en", int'(a_pool_en), 1);
      chk("idle_busy", int'(a_busy), 0);
    end
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    a_frame(1'b0, -1, -1);
    a_frame(1'b1, -1, -1);
    a_frame(1'b0, 7, -1);
    a_frame(1'b0, -1, 9);
    a_frame(1'b0, -1, -1);
    b_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/maxpool22_ctrl.md
# maxpool22_ctrl

Sequencer for the 2x2 max-pool line buffer (`maxpool22`). It accepts a raster-order pixel stream for one MAP_SIZE x MAP_SIZE feature map per frame and drives the pool's active-low shift enable. It tracks row and column position and flags the cycles when the pool's combinational `maxOut` holds a complete, aligned 2x2 window. It sits between the conv-layer output stream and the pool, and owns input/output handshaking and frame boundaries.

## Interface
- MAP_SIZE, 28: input map width/height in pixels; must be even, ≥ 2.
- CW, $clog2(MAP_SIZE): row/column counter width (derived).
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to begin a frame; ignored unless state is IDLE.
- in_valid  in  1  upstream pixel present this cycle.
- in_ready  out  1  controller accepts a pixel this cycle.
- out_ready  in  1  downstream accepts the pooled result.
- pool_en  out  1  to `maxpool22.en`; active-low: 0 = shift one pixel in this edge.
- out_valid  out  1  `maxOut` currently holds a complete window.
- out_row, out_col  out  CW-1 each  pooled-map coordinates of the current result.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse after the last result of a frame is taken.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE: start → RUN. Clears row/col counters and the result counter.
  - RUN: accepts pixels. After the last pixel (row = col = MAP_SIZE-1) is accepted → DRAIN.
  - DRAIN: waits until the final result handshakes (out_valid && out_ready) → DONE.
  - DONE: asserts frame_done for 1 cycle → IDLE.
- in_ready = (state == RUN) && !(out_valid && !out_ready).
  - The pool is never shifted while an unconsumed window is pending, because a shift would overwrite `maxOut`.
- Accept = in_valid && in_ready. pool_en = ~accept, so the pool shifts exactly once per accepted pixel.
- Position counters col/row advance on accept:
  - col wraps MAP_SIZE-1 → 0 and increments row.
  - row stops at MAP_SIZE-1; the frame ends there.
- Window flag: an accept at (row odd, col odd) sets out_valid on the next edge, with out_row = row>>1 and out_col = col>>1 captured.
- out_valid clears on out_valid && out_ready, unless the same cycle's accept produces a new window. That cannot happen: an accept needs out_ready when out_valid is set, and consecutive windows are ≥ 2 accepts apart.
- Results per frame: (MAP_SIZE/2)^2, i.e. 196 at the default.
- in_valid while not in RUN: ignored, in_ready = 0.
- start while busy: ignored.

## Timing
- Reset values: state = IDLE, counters = 0, in_ready = 0, pool_en = 1, out_valid = 0, out_row = out_col = 0, busy = 0, frame_done = 0.
- Reset mid-frame: all of the above apply immediately (asynchronous). The pool's own contents are not this block's concern, since the pool shares rst.
- start → in_ready high: 1 cycle (registered state).
- Accept of the window-completing pixel at edge N → out_valid high after edge N, with `maxOut` valid in that same cycle.
- Back-to-back: with in_valid and out_ready held high, the block accepts one pixel per cycle with no bubbles. One result is produced every 2 cycles on odd rows; even rows produce none.
- Last pixel accepted at edge N, out_ready high → DRAIN for cycle N+1. The handshake at edge N+2 is followed by DONE (frame_done high) for one cycle, then IDLE.
- in_ready is combinational from state, out_valid and out_ready. No combinational path from in_valid to any output except pool_en.

## Structure
- Shared package: state encoding (IDLE/RUN/DRAIN/DONE) and a function returning the counter width for a given MAP_SIZE, so other layer controllers reuse them.
- No sub-module is needed. Optionally, the row/col counter pair is factored as `raster_counter #(MAP_SIZE)`, reusable by the conv controllers.
- The bench instantiates `maxpool22_ctrl` together with `maxpool22` to check window contents end to end.

## Test plan
- Reset: hold rst = 0 with start and in_valid toggling → all outputs at reset values; pool_en = 1 throughout.
- MAP_SIZE = 4, pixels 0..15 streamed, out_ready = 1 → 4 results: 5, 7, 13, 15 at (0,0), (0,1), (1,0), (1,1). frame_done appears 2 cycles after the last accept.
- Backpressure: out_ready = 0 when the first result appears → in_ready = 0 and pool_en = 1 until out_ready rises; maxOut stays 5 for the whole stall. The stream then resumes without loss.
- in_valid gaps (random 50%) on a MAP_SIZE = 28 frame of signed values, including negatives → 196 results match a software 2x2 max-pool, in raster order.
- Start while busy, in_valid while IDLE → no effect on counters or pool_en.
- rst pulsed low at pixel 9 of a frame → immediate IDLE. A new start followed by a full frame yields correct results with no stale out_valid.
